// File: rtl/adam_pause_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : adam_pause_seq_if
//  Purpose  : Handshake bundle between the ADAM pause/reset sequencer and
//             its surroundings: upstream pause req/ack, per-target reset,
//             per-target pause req/ack, and status flags.
//  Modports : master - the sequencer (drives acks, target resets/requests)
//             slave  - board logic + targets (drive pause_req, target acks)
//  Revision : 1.0 - initial release
// ============================================================================
interface adam_pause_seq_if #(
    parameter int NO_TGTS = 4
);
    logic               pause_req;
    logic               pause_ack;
    logic [NO_TGTS-1:0] tgt_rst;
    logic [NO_TGTS-1:0] tgt_pause_req;
    logic [NO_TGTS-1:0] tgt_pause_ack;
    logic               timeout_err;
    logic               busy;

    modport master (
        input  pause_req,
        input  tgt_pause_ack,
        output pause_ack,
        output tgt_rst,
        output tgt_pause_req,
        output timeout_err,
        output busy
    );

    modport slave (
        output pause_req,
        output tgt_pause_ack,
        input  pause_ack,
        input  tgt_rst,
        input  tgt_pause_req,
        input  timeout_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/adam_pause_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adam_pause_seq
//  Purpose  : System reset and pause sequencer for the ADAM SoC top level.
//             Stretches the synchronized board reset, releases target resets
//             one by one, then runs a four-phase pause handshake across the
//             targets (forward order to resume, reverse order to pause).
//  Ports    : clk        - system clock
//             rst        - asynchronous active-high reset
//             ext_rst_n  - asynchronous board reset (active-low)
//             bus        - adam_pause_seq_if.master: pause_req/pause_ack,
//                          tgt_rst, tgt_pause_req/ack, timeout_err, busy
//  Revision : 1.0 - initial release
// ============================================================================
module adam_pause_seq #(
    parameter int NO_TGTS    = 4,
    parameter int RST_CYCLES = 16,
    parameter int TIMEOUT    = 255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         ext_rst_n,
    adam_pause_seq_if.master  bus
);
    localparam int c_HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int c_WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int c_IDX_W  = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1;

    localparam logic [c_HOLD_W-1:0] c_HOLD_LIM = c_HOLD_W'(RST_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(NO_TGTS - 1);
    localparam bit                  c_TO_EN    = (TIMEOUT > 0);
    localparam logic [c_WAIT_W-1:0] c_TO_LIM   = (TIMEOUT > 0) ? c_WAIT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_RESUME  = 3'd3,
        ST_RUN     = 3'd4,
        ST_PAUSE   = 3'd5
    } state_t;

    logic [1:0]          r_sync;
    state_t              r_state,       w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx,         w_idx_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt,    w_hold_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt,    w_wait_nxt;
    logic [NO_TGTS-1:0]  r_tgt_rst,     w_tgt_rst_nxt;
    logic [NO_TGTS-1:0]  r_tgt_req,     w_tgt_req_nxt;
    logic                r_pause_ack,   w_pause_ack_nxt;
    logic                r_timeout_err, w_timeout_err_nxt;
    logic                r_busy,        w_busy_nxt;

    logic w_ack_sel;
    logic w_step_to;

    assign w_ack_sel = bus.tgt_pause_ack[r_idx];
    // Final allowed wait cycle for the current target: this edge gives up.
    assign w_step_to = c_TO_EN && (r_wait_cnt == c_TO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync        <= 2'b00;
            r_state       <= ST_HOLD;
            r_idx         <= '0;
            r_hold_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_tgt_rst     <= '1;
            r_tgt_req     <= '1;
            r_pause_ack   <= 1'b1;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            r_sync        <= {r_sync[0], ext_rst_n};
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_tgt_rst     <= w_tgt_rst_nxt;
            r_tgt_req     <= w_tgt_req_nxt;
            r_pause_ack   <= w_pause_ack_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_hold_nxt        = r_hold_cnt;
        w_wait_nxt        = r_wait_cnt;
        w_tgt_rst_nxt     = r_tgt_rst;
        w_tgt_req_nxt     = r_tgt_req;
        w_pause_ack_nxt   = r_pause_ack;
        w_timeout_err_nxt = r_timeout_err;
        w_busy_nxt        = r_busy;

        if (!r_sync[1]) begin
            // Board reset held: park everything and restart the hold count.
            w_state_nxt       = ST_HOLD;
            w_idx_nxt         = '0;
            w_hold_nxt        = '0;
            w_wait_nxt        = '0;
            w_tgt_rst_nxt     = '1;
            w_tgt_req_nxt     = '1;
            w_pause_ack_nxt   = 1'b1;
            w_timeout_err_nxt = 1'b0;
            w_busy_nxt        = 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == c_HOLD_LIM) begin
                        w_state_nxt = ST_RELEASE;
                        w_idx_nxt   = '0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    w_tgt_rst_nxt[r_idx] = 1'b0;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = ST_PAUSED;
                        w_idx_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
                ST_PAUSED: begin
                    if (!bus.pause_req) begin
                        w_state_nxt = ST_RESUME;
                        w_idx_nxt   = '0;
                        w_wait_nxt  = '0;
                        w_busy_nxt  = 1'b1;
                    end
                end
                ST_RESUME: begin
                    w_tgt_req_nxt[r_idx] = 1'b0;
                    if (!w_ack_sel || w_step_to) begin
                        // A timed-out step advances as if acked, flagging it.
                        if (w_ack_sel) begin
                            w_timeout_err_nxt = 1'b1;
                        end
                        w_wait_nxt = '0;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt     = ST_RUN;
                            w_idx_nxt       = '0;
                            w_pause_ack_nxt = 1'b0;
                            w_busy_nxt      = 1'b0;
                        end else begin
                            w_idx_nxt = r_idx + c_IDX_W'(1);
                        end
                    end else begin
                        w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.pause_req) begin
                        w_state_nxt = ST_PAUSE;
                        w_idx_nxt   = c_LAST_IDX;
                        w_wait_nxt  = '0;
                        w_busy_nxt  = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    w_tgt_req_nxt[r_idx] = 1'b1;
                    if (w_ack_sel || w_step_to) begin
                        if (!w_ack_sel) begin
                            w_timeout_err_nxt = 1'b1;
                        end
                        w_wait_nxt = '0;
                        if (r_idx == '0) begin
                            w_state_nxt     = ST_PAUSED;
                            w_pause_ack_nxt = 1'b1;
                            w_busy_nxt      = 1'b0;
                        end else begin
                            w_idx_nxt = r_idx - c_IDX_W'(1);
                        end
                    end else begin
                        w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                end
            endcase
        end
    end

    assign bus.pause_ack     = r_pause_ack;
    assign bus.tgt_rst       = r_tgt_rst;
    assign bus.tgt_pause_req = r_tgt_req;
    assign bus.timeout_err   = r_timeout_err;
    assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_adam_pause_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adam_pause_seq
//  Purpose  : Self-checking bench for adam_pause_seq. A procedural reference
//             model walks the reset/pause sequence as a program (one step per
//             clock) and the DUT outputs are compared to it every cycle.
//             Targets answer with ack = request delayed two cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adam_pause_seq;
    localparam int N    = 3;
    localparam int RSTC = 4;
    localparam int TO   = 8;

    localparam int PH_HOLD    = 0;
    localparam int PH_RELEASE = 1;
    localparam int PH_PAUSED  = 2;
    localparam int PH_RESUME  = 3;
    localparam int PH_RUN     = 4;
    localparam int PH_PAUSE   = 5;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic ext_rst_n = 1'b1;
    logic req_drv   = 1'b0;

    logic [N-1:0] ack_d1 = '1;
    logic [N-1:0] ack_d2 = '1;
    logic [N-1:0] stuck  = '0;

    int n_tests = 0;
    int n_fail  = 0;

    adam_pause_seq_if #(.NO_TGTS(N)) bus ();

    adam_pause_seq #(
        .NO_TGTS    (N),
        .RST_CYCLES (RSTC),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_rst_n (ext_rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Targets: ack follows request two cycles later; 'stuck' forces acks low.
    assign bus.pause_req     = req_drv;
    assign bus.tgt_pause_ack = ack_d2 & ~stuck;
    always @(negedge clk) begin
        ack_d1 <= bus.tgt_pause_req;
        ack_d2 <= ack_d1;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [N-1:0] exp_rst, exp_req, m_ack;
    logic         exp_pack, exp_err, exp_busy;
    logic         m_s0, m_s1, m_ok, m_abort, m_req;
    int           m_phase;
    int           m_n;

    function automatic void exp_reset();
        exp_rst  = '1;
        exp_req  = '1;
        exp_pack = 1'b1;
        exp_err  = 1'b0;
        exp_busy = 1'b1;
        m_phase  = PH_HOLD;
    endfunction

    // One clock of the model; wakes early on an asynchronous reset.
    task automatic tick();
        @(posedge clk or posedge rst);
        m_req = bus.pause_req;
        m_ack = bus.tgt_pause_ack;
        if (rst) begin
            m_s0 = 1'b0;
            m_s1 = 1'b0;
            m_ok = 1'b0;
        end else begin
            m_ok = m_s1;
            m_s1 = m_s0;
            m_s0 = ext_rst_n;
        end
        if (!m_ok) begin
            m_abort = 1'b1;
            exp_reset();
        end
    endtask

    // Drive target i's request to lvl and wait for its ack (or give up).
    task automatic step(input int i, input logic lvl);
        int w;
        w = 0;
        forever begin
            tick();
            if (m_abort) return;
            exp_req[i] = lvl;
            if (m_ack[i] == lvl) return;
            w++;
            if (w == TO) begin
                exp_err = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_model();
        m_abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            tick();
            if (m_abort) return;
            exp_rst[i] = 1'b0;
        end
        exp_busy = 1'b0;
        m_phase  = PH_PAUSED;
        forever begin
            do begin
                tick();
                if (m_abort) return;
            end while (m_req);
            exp_busy = 1'b1;
            m_phase  = PH_RESUME;
            for (int i = 0; i < N; i++) begin
                step(i, 1'b0);
                if (m_abort) return;
            end
            exp_pack = 1'b0;
            exp_busy = 1'b0;
            m_phase  = PH_RUN;
            do begin
                tick();
                if (m_abort) return;
            end while (!m_req);
            exp_busy = 1'b1;
            m_phase  = PH_PAUSE;
            for (int i = N - 1; i >= 0; i--) begin
                step(i, 1'b1);
                if (m_abort) return;
            end
            exp_pack = 1'b1;
            exp_busy = 1'b0;
            m_phase  = PH_PAUSED;
        end
    endtask

    initial begin : ref_model
        m_s0 = 1'b0;
        m_s1 = 1'b0;
        m_ok = 1'b0;
        exp_reset();
        forever begin
            exp_reset();
            m_n = 0;
            while (m_n < RSTC) begin
                tick();
                if (m_ok) m_n++;
                else      m_n = 0;
            end
            m_phase = PH_RELEASE;
            run_model();
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers (only the stimulus process calls these)
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check("tgt_rst",       32'(bus.tgt_rst),       32'(exp_rst));
        check("tgt_pause_req", 32'(bus.tgt_pause_req), 32'(exp_req));
        check("pause_ack",     32'(bus.pause_ack),     32'(exp_pack));
        check("timeout_err",   32'(bus.timeout_err),   32'(exp_err));
        check("busy",          32'(bus.busy),          32'(exp_busy));
    endtask

    task automatic wait_phase(input int ph, input int max_cyc, input string tag);
        int k;
        k = 0;
        while (m_phase != ph && k < max_cyc) begin
            cyc();
            k++;
        end
        n_tests++;
        assert (m_phase == ph) else begin
            n_fail++;
            $error("FAIL %s: phase %0d expected %0d after %0d cycles", tag, m_phase, ph, k);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tgt_rst"}, 32'(bus.tgt_rst),       32'h7);
        check({tag, "_req"},     32'(bus.tgt_pause_req), 32'h7);
        check({tag, "_ack"},     32'(bus.pause_ack),     32'h1);
        check({tag, "_err"},     32'(bus.timeout_err),   32'h0);
        check({tag, "_busy"},    32'(bus.busy),          32'h1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int pa_cnt;
    int k;

    initial begin : stim
        repeat (3) cyc();
        check_reset_outputs("por");
        rst = 1'b0;

        // Power-up: release order and first resume are followed by the model.
        wait_phase(PH_RUN, 100, "powerup_run");
        check("run_pack", 32'(bus.pause_ack), 32'h0);
        check("run_busy", 32'(bus.busy),      32'h0);

        // Randomly spaced pause/resume rounds.
        repeat (4) begin
            repeat ($urandom_range(1, 5)) cyc();
            req_drv = 1'b1;
            wait_phase(PH_PAUSED, 60, "rnd_paused");
            check("rnd_paused_ack", 32'(bus.pause_ack), 32'h1);
            repeat ($urandom_range(0, 4)) cyc();
            req_drv = 1'b0;
            wait_phase(PH_RUN, 60, "rnd_run");
            check("rnd_run_ack", 32'(bus.pause_ack), 32'h0);
        end

        // Random pause_req noise, including toggles mid-sequence.
        repeat (80) begin
            cyc();
            req_drv = 1'($urandom_range(0, 1));
        end
        req_drv = 1'b0;
        wait_phase(PH_RUN, 80, "noise_run");

        // Timeout: target 1 never acknowledges the pause.
        stuck   = 3'b010;
        req_drv = 1'b1;
        wait_phase(PH_PAUSED, 80, "to_paused");
        check("to_err_set",   32'(bus.timeout_err), 32'h1);
        check("to_pause_ack", 32'(bus.pause_ack),   32'h1);
        req_drv = 1'b0;
        wait_phase(PH_RUN, 60, "to_run");
        check("to_err_sticky", 32'(bus.timeout_err), 32'h1);
        stuck = 3'b000;

        // Rescinded pause: one-cycle pulse gives a full pause then resume.
        cyc();
        req_drv = 1'b1;
        cyc();
        req_drv = 1'b0;
        pa_cnt  = 0;
        k       = 0;
        while (m_phase != PH_RUN && k < 80) begin
            cyc();
            if (bus.pause_ack && !bus.busy) pa_cnt++;
            k++;
        end
        wait_phase(PH_RUN, 1, "resc_run");
        check("resc_paused_cycles", 32'(pa_cnt), 32'd1);

        // Board reset pulse while pausing target 1.
        req_drv = 1'b1;
        k = 0;
        while (!(m_phase == PH_PAUSE && exp_req == 3'b110) && k < 40) begin
            cyc();
            k++;
        end
        wait_phase(PH_PAUSE, 0, "ext_at_pause");
        ext_rst_n = 1'b0;
        cyc();
        ext_rst_n = 1'b1;
        cyc();
        cyc();
        check_reset_outputs("ext");
        req_drv = 1'b0;
        wait_phase(PH_RUN, 100, "ext_run");

        // Asynchronous rst in the middle of a resume.
        req_drv = 1'b1;
        wait_phase(PH_PAUSED, 60, "arst_paused");
        req_drv = 1'b0;
        wait_phase(PH_RESUME, 10, "arst_resume");
        cyc();
        #2 rst = 1'b1;
        #1 check_reset_outputs("arst");
        repeat (2) cyc();
        rst = 1'b0;
        wait_phase(PH_RUN, 100, "arst_run");
        check("arst_err_clear", 32'(bus.timeout_err), 32'h0);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adam_pause_seq.md
Name: adam_pause_seq

Overview:
- System reset and pause sequencer for the ADAM SoC top level.
- Stretches and synchronizes the board reset button into an ordered per-target reset release.
- Drives the four-phase pause req/ack handshake across NO_TGTS targets (memories, peripherals) one target at a time.
- Presents a single upstream pause req/ack pair. Sits between the board-level reset/pause logic and the adam core and memory instances.

Parameters:
- NO_TGTS, 4, number of sequenced targets (1..32).
- RST_CYCLES, 16, cycles ext_rst_n must stay high (post-sync) before the first reset release (1..65535).
- TIMEOUT, 255, max cycles to wait for a target ack per step; 0 disables the timeout (wait forever).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ext_rst_n  in  1  asynchronous board reset, active-low; synchronized internally by 2 FFs.
- pause_req  in  1  upstream pause request.
- pause_ack  out  1  upstream pause acknowledge; 1 = all targets paused.
- tgt_rst  out  NO_TGTS  per-target reset, active-high.
- tgt_pause_req  out  NO_TGTS  per-target pause request.
- tgt_pause_ack  in  NO_TGTS  per-target pause acknowledge.
- timeout_err  out  1  sticky flag: some ack step timed out.
- busy  out  1  sequence in progress.

Behaviour:
- Reset: clk and rst only; reset is asynchronous and active-high.
- All outputs are registered. Values while rst=1:
  - tgt_rst all 1, tgt_pause_req all 1.
  - pause_ack=1, timeout_err=0, busy=1.
  - Sync chain 0, state HOLD, counters 0.
- Sync: ext_rst_n passes through 2 FFs (cleared to 0 by rst).
- Synced ext_rst_n=0 in any state:
  - Next edge: state HOLD, all tgt_rst=1, all tgt_pause_req=1, pause_ack=1, timeout_err=0, hold counter=0.
- States: HOLD, RELEASE, PAUSED, RESUME, RUN, PAUSE.
- HOLD: counter increments while synced ext_rst_n=1. When the counter reaches RST_CYCLES-1, go to RELEASE with idx=0.
- RELEASE:
  - Clear tgt_rst[idx], one target per cycle in order 0..NO_TGTS-1.
  - After the last target, go to PAUSED. tgt_pause_req stays all 1 throughout.
- PAUSED:
  - pause_ack=1, busy=0.
  - If pause_req=0, go to RESUME with idx=0 and wait counter cleared; otherwise stay.
- RESUME (forward order):
  - Step idx: tgt_pause_req[idx]=0; wait for tgt_pause_ack[idx]==0.
  - On match, idx++ and clear the wait counter. A target whose ack already matches costs exactly 1 cycle.
  - After the last target: RUN, pause_ack<=0 on the same edge.
- RUN:
  - pause_ack=0, busy=0.
  - If pause_req=1, go to PAUSE with idx=NO_TGTS-1.
- PAUSE (reverse order, NO_TGTS-1 down to 0):
  - Set tgt_pause_req[idx]=1; wait for tgt_pause_ack[idx]==1.
  - After index 0 completes: PAUSED, pause_ack<=1.
- Upstream pause_req is sampled only in RUN and PAUSED.
  - Toggling it during RESUME or PAUSE is ignored; the sequence completes first.
  - A rescinded pause therefore ends in PAUSED, which then resumes because pause_req=0.
- Timeout (TIMEOUT>0):
  - The wait counter increments each cycle the ack mismatches.
  - If it reaches TIMEOUT, set timeout_err=1 (sticky) and advance to the next index as if acked. The tgt_pause_req value stays as driven.
  - timeout_err clears only on rst or ext reset.
- busy=1 in HOLD, RELEASE, RESUME, PAUSE; busy=0 in RUN and PAUSED.
- Latency from ext_rst_n rising to PAUSED: 2 (sync) + RST_CYCLES + NO_TGTS cycles.
- Counter widths: $clog2(RST_CYCLES+1), $clog2(TIMEOUT+1) (min 1), $clog2(NO_TGTS) (min 1).

Test Plan:
- Bench config: NO_TGTS=3, RST_CYCLES=4, TIMEOUT=8, targets model ack = req delayed 2 cycles.
- Power-up reset:
  - Stimulus: release rst with ext_rst_n=1, pause_req=0.
  - Required: tgt_rst deasserts 0, 1, 2 on consecutive cycles, 6 cycles after rst falls; PAUSED lasts 1 cycle.
  - Required: tgt_pause_req bits clear in order 0, 1, 2, each ≥3 cycles apart; then pause_ack=0, busy=0.
- Pause/resume:
  - Stimulus: in RUN, set pause_req=1.
  - Required: tgt_pause_req raises 2, then 1, then 0; pause_ack=1 only after ack[0]=1.
  - Stimulus: drop pause_req.
  - Required: resume runs 0, 1, 2; pause_ack=0.
- Timeout:
  - Stimulus: hold tgt_pause_ack[1]=0 forever, then request pause.
  - Required: after 8 wait cycles on idx 1, timeout_err=1, sequence continues to idx 0, pause_ack=1; timeout_err stays 1 after resume.
- Rescinded pause:
  - Stimulus: pause_req pulses high for 1 cycle in RUN.
  - Required: full pause of all 3 targets, pause_ack=1 for 1 cycle, then automatic resume back to RUN.
- Mid-sequence ext reset:
  - Stimulus: ext_rst_n=0 for 1 cycle during PAUSE at idx 1.
  - Required: 2 cycles later all tgt_rst=1, tgt_pause_req=3'b111, pause_ack=1, timeout_err=0; full power-up sequence repeats.
- Async rst:
  - Stimulus: assert rst mid-RESUME, not on a clock edge.
  - Required: outputs take reset values immediately, without waiting for a clock edge.
